// File: rtl/multpool_rdata_serializer_if.sv
// Stream bundle between the read-data mux, the serializer and the AHB-side read path.
// master = serializer view, slave = producer/consumer environment view.
interface multpool_rdata_serializer_if #(
    parameter int NBITS = 256,
    parameter int DW    = 32
);
    localparam int NWORDS = 3*NBITS/DW;
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic [3*NBITS-1:0] in_data;
    logic               in_valid;
    logic               in_busy;
    logic [DW-1:0]      ser_data;
    logic               ser_valid;
    logic               ser_ready;
    logic               ser_last;
    logic [CW-1:0]      beat_idx;

    modport master (
        input  in_data, in_valid, ser_ready,
        output in_busy, ser_data, ser_valid, ser_last, beat_idx
    );

    modport slave (
        output in_data, in_valid, ser_ready,
        input  in_busy, ser_data, ser_valid, ser_last, beat_idx
    );
endinterface

// File: rtl/multpool_rdata_serializer.sv
// Single-entry capture of the 3*NBITS read word, streamed as NWORDS DW-bit beats.
// MULTPOOL_SER_MSW_FIRST_EN: send the most-significant word first (default LSW first).
module multpool_rdata_serializer #(
    parameter int NBITS = 256,
    parameter int DW    = 32
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    multpool_rdata_serializer_if.master  bus,
    output logic                         ovf,
    input  logic                         ovf_clr
);
    localparam int NWORDS = 3*NBITS/DW;
    localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS-1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                      state_q, state_d;
    logic [NWORDS-1:0][DW-1:0]   buf_q;
    logic [CW-1:0]               idx_q, idx_d;
    logic [CW-1:0]               sel;
    logic                        cap, ovf_set, is_last, accept;

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q <= IDLE;
            buf_q   <= '0;
            idx_q   <= '0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (cap)
                buf_q <= bus.in_data;
            if (ovf_set)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cap     = 1'b0;
        ovf_set = 1'b0;
        is_last = (state_q == SEND) && (idx_q == LAST_IDX);
        accept  = (state_q == SEND) && bus.ser_ready;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    cap     = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (accept && is_last) begin
                    // back-to-back word: recapture on the final handshake, no bubble
                    if (bus.in_valid) begin
                        cap   = 1'b1;
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (accept)
                        idx_d = idx_q + 1'b1;
                    ovf_set = bus.in_valid;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MULTPOOL_SER_MSW_FIRST_EN
    assign sel = LAST_IDX - idx_q;
`else
    assign sel = idx_q;
`endif

    assign bus.ser_valid = (state_q == SEND);
    assign bus.ser_last  = is_last;
    assign bus.ser_data  = bus.ser_valid ? buf_q[sel] : '0;
    assign bus.beat_idx  = idx_q;
    assign bus.in_busy   = (state_q == SEND) && !(is_last && bus.ser_ready);

endmodule

// File: tb/tb_multpool_rdata_serializer.sv
// Randomized and scenario stimulus for multpool_rdata_serializer, checked against a beat-queue model.
module tb_multpool_rdata_serializer;
    localparam int NBITS  = 256;
    localparam int DW     = 32;
    localparam int NWORDS = 3*NBITS/DW;
    localparam int WB     = 3*NBITS;

    logic hclk = 1'b0;
    logic hresetn;
    logic ovf, ovf_clr;

    multpool_rdata_serializer_if #(.NBITS(NBITS), .DW(DW)) bus ();

    multpool_rdata_serializer #(.NBITS(NBITS), .DW(DW)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 hclk = ~hclk;

    int n_tests = 0;
    int n_fail  = 0;

    // model: beats still owed to the consumer, in delivery order
    logic [DW-1:0] beats[$];
    bit            m_ovf;
    bit            m_fresh;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [WB-1:0] mk(input logic [31:0] base);
        logic [WB-1:0] w;
        for (int k = 0; k < NWORDS; k++) w[k*DW +: DW] = base + 32'(k);
        return w;
    endfunction

    function automatic logic [WB-1:0] rnd_word();
        logic [WB-1:0] w;
        for (int k = 0; k < NWORDS; k++) w[k*DW +: DW] = $urandom;
        if ($urandom_range(0, 15) == 0) w = '0;
        return w;
    endfunction

    // One clock: apply inputs, check outputs mid-cycle, advance the model to the edge.
    task automatic cyc(input bit iv, input logic [WB-1:0] d, input bit rdy,
                       input bit clr, input bit rstn);
        int sz;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.ser_ready = rdy;
        ovf_clr       = clr;
        hresetn       = rstn;
        @(negedge hclk);
        sz = beats.size();
        chk("ser_valid", 32'(bus.ser_valid), 32'(sz > 0));
        chk("ser_data",  bus.ser_data, (sz > 0) ? beats[0] : 32'h0);
        chk("ser_last",  32'(bus.ser_last), 32'(sz == 1));
        chk("in_busy",   32'(bus.in_busy), 32'((sz > 0) && !(sz == 1 && rdy)));
        chk("ovf",       32'(ovf), 32'(m_ovf));
        if (sz > 0)
            chk("beat_idx", 32'(bus.beat_idx), 32'(NWORDS - sz));
        else if (m_fresh)
            chk("beat_idx_rst", 32'(bus.beat_idx), 32'h0);
        if (!rstn) begin
            beats.delete();
            m_ovf   = 1'b0;
            m_fresh = 1'b1;
        end else begin
            bit drop;
            drop = 1'b0;
            if (sz > 0 && rdy) void'(beats.pop_front());
            if (iv) begin
                if (beats.size() == 0) begin
                    for (int k = 0; k < NWORDS; k++) begin
`ifdef MULTPOOL_SER_MSW_FIRST_EN
                        beats.push_back(d[(NWORDS-1-k)*DW +: DW]);
`else
                        beats.push_back(d[k*DW +: DW]);
`endif
                    end
                    m_fresh = 1'b0;
                end else begin
                    drop = 1'b1;
                end
            end
            if (drop) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, rdy, 1'b0, 1'b1);
    endtask

    initial begin
        logic [WB-1:0] wa, wb;
        wa = mk(32'hA000_0000);
        wb = mk(32'hB000_0000);
        bus.in_valid = 1'b0; bus.in_data = '0; bus.ser_ready = 1'b0;
        ovf_clr = 1'b0; hresetn = 1'b0;
        m_ovf = 1'b0; m_fresh = 1'b1;
        repeat (2) @(posedge hclk);
        #1;

        // reset state, then a full word at full rate
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, wa, 1'b1, 1'b0, 1'b1);
        idle(26, 1'b1);

        // stalls: ready pattern 1,0,0
        cyc(1'b1, wa, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 75; i++) cyc(1'b0, '0, (i % 3) == 0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // back-to-back word on acceptance of beat 23
        cyc(1'b1, wa, 1'b1, 1'b0, 1'b1);
        for (int j = 0; j < NWORDS; j++) cyc(j == NWORDS-1, wb, 1'b1, 1'b0, 1'b1);
        idle(26, 1'b1);

        // drop at beat 5, clear, then clear coincident with a new drop
        cyc(1'b1, wa, 1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) cyc(j == 5, wb, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, wb, 1'b1, 1'b1, 1'b1);
        idle(20, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b1);
        idle(2, 1'b1);

        // reset mid-stream at beat 10, then a fresh word
        cyc(1'b1, wa, 1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 10; j++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, wb, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        cyc(1'b1, wb, 1'b1, 1'b0, 1'b1);
        idle(26, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 7) == 0, rnd_word(), $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 499) != 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multpool_rdata_serializer.md
Name: multpool_rdata_serializer

Overview:
- Downstream stage of the multpool read-data mux.
- Captures the registered 3*NBITS-wide OR-reduced read word and streams it as NWORDS beats of DW bits over a valid/ready interface to the AHB-side read path.
- Single-entry capture buffer; indicates busy to the read issuer; flags dropped words.

Parameters:
NBITS, 256, operand width; captured word is 3*NBITS bits
DW, 32, output beat width; 3*NBITS must be an integer multiple of DW
NWORDS, 3*NBITS/DW (localparam, 24 by default), beats per captured word
CW, $clog2(NWORDS) (localparam), beat index width

Ports:
hclk  input  1  clock; all logic on rising edge
hresetn  input  1  reset, synchronous, active-low
in_data  input  3*NBITS  wide read word from the read-data mux
in_valid  input  1  in_data valid this cycle; single-cycle qualifier
in_busy  output  1  high while a word is held and not completing; issuer must not raise valid_rd
ser_data  output  DW  current beat; 0 when ser_valid=0
ser_valid  output  1  beat valid
ser_ready  input  1  consumer accepts beat
ser_last  output  1  high with the final beat (index NWORDS-1)
beat_idx  output  CW  index of the current beat
ovf  output  1  sticky: in_valid arrived while busy; word dropped
ovf_clr  input  1  clears ovf

Behaviour:
- Reset (hresetn=0 at posedge): state IDLE, buffer=0, beat index=0, ovf=0. Outputs ser_valid=0, ser_last=0, ser_data=0, beat_idx=0, in_busy=0. Reset mid-stream abandons the word with no further beats.
- States:
  - IDLE: in_busy=0, ser_valid=0. in_valid=1 captures in_data into the buffer, sets index=0, goes to SEND. First ser_valid occurs in the cycle after in_valid (latency 1).
  - SEND: ser_valid=1; ser_data = buffer[idx*DW +: DW]; ser_last = (idx==NWORDS-1).
    - Beat accepted (ser_valid & ser_ready), idx<NWORDS-1: idx increments.
    - Last beat accepted: go to IDLE, unless in_valid=1 in that same cycle. Then capture the new word, idx=0, stay in SEND. No bubble between words.
- ser_valid & !ser_ready: ser_data, ser_last and beat_idx hold stable. ser_valid never drops before acceptance.
- in_busy = (state==SEND) & !(ser_last & ser_ready). Combinational from ser_ready.
- in_valid in SEND other than on last-beat acceptance: word dropped, buffer untouched, ovf set next cycle.
- ovf_clr=1 clears ovf next cycle. If set and clear occur in the same cycle, set wins.
- An all-zero in_data with in_valid=1 is a legal word and is streamed normally. Only in_valid qualifies data.
- No arithmetic; the index wraps only via the return to 0 on capture.

Optional Feature:
- Macro: MULTPOOL_SER_MSW_FIRST_EN
- Defined: beat k carries buffer[(NWORDS-1-k)*DW +: DW], i.e. most-significant word first. beat_idx still counts 0..NWORDS-1 and ser_last still marks k=NWORDS-1.
- Undefined: least-significant word first, as in Behaviour.

Test Plan (NBITS=256, DW=32, NWORDS=24):
1. in_valid pulse, in_data[32k+31:32k]=32'hA000_0000+k, ser_ready=1 -> ser_valid from the next cycle for 24 consecutive cycles. Data A0000000..A0000017 in order. ser_last only on beat 23 (beat_idx=23). in_busy low again after the last beat.
2. Same word, ser_ready toggling 1,0,0,1,... -> no beat skipped or duplicated. ser_data held during stalls. Exactly 24 accepted beats.
3. Second in_valid (data 32'hB...) coincident with acceptance of beat 23 -> next cycle ser_valid=1, beat_idx=0, ser_data=B0000000. ovf stays 0.
4. Second in_valid at beat 5 of a word -> first word completes unchanged (beat 6 = A0000006). ovf=1 the next cycle. ovf_clr pulse -> ovf=0. ovf_clr coincident with a new drop -> ovf remains 1.
5. hresetn=0 for one cycle at beat 10 -> next cycle ser_valid=0, beat_idx=0, in_busy=0, ovf=0. A new in_valid then streams from beat 0.
6. With MULTPOOL_SER_MSW_FIRST_EN, scenario 1 -> first beat A0000017, last beat A0000000 with ser_last=1.
